// File: rtl/scsi_slave_bridge.sv
// -----------------------------------------------------------------------------
// scsi_slave_bridge
//
// Purpose: bridges a Zorro III slave cycle aimed at SCSI space onto the slave
// bus of an NCR 53C710. It drives the chip select first, then the access
// strobe. It waits for the chip's SLACK_n acknowledge, or forces an
// acknowledge after a timeout. It then returns an acknowledge to the Z3 FSM
// and holds it until the Z3 cycle ends. A recovery gap follows every access.
//
// Ports:
//   CLK, RESET       single clock, synchronous active-high reset
//   scsi_cycle       upstream Z3 FSM owns a SCSI-space cycle
//   z3_data          upstream Z3 FSM is in its data phase
//   FCS_n_sync       synchronised FCS_n (high = cycle ended/aborted)
//   READ             1 = read, 0 = write
//   DS_n_sync[3:0]   synchronised data strobes (byte lanes for writes)
//   SLACK_n          NCR slave acknowledge, asynchronous to CLK
//   ncr_cs_n         NCR chip select
//   ncr_rw           NCR read/write (1 = read)
//   ncr_strb_n       NCR access strobe
//   ncr_be_n[3:0]    NCR byte enables
//   scsi_dtack       acknowledge level to the Z3 FSM (high only in ACK)
//   rd_latch         one-cycle pulse: latch NCR read data into Zorro buffer
//   timeout          one-cycle pulse on a forced acknowledge
//   timeout_count    saturating number of forced acknowledges
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module scsi_slave_bridge #(
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned RECOVERY_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       scsi_cycle,
  input  logic       z3_data,
  input  logic       FCS_n_sync,
  input  logic       READ,
  input  logic [3:0] DS_n_sync,
  input  logic       SLACK_n,
  output logic       ncr_cs_n,
  output logic       ncr_rw,
  output logic       ncr_strb_n,
  output logic [3:0] ncr_be_n,
  output logic       scsi_dtack,
  output logic       rd_latch,
  output logic       timeout,
  output logic [7:0] timeout_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK,
    RECOVER
  } state_e;

  localparam logic [7:0] SetupLoad   = 8'(SETUP_CYCLES);
  localparam logic [7:0] RecoverLoad = 8'(RECOVERY_CYCLES);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] slack_sync_q, slack_sync_d;
  logic       ncr_cs_n_q, ncr_cs_n_d;
  logic       ncr_rw_q, ncr_rw_d;
  logic       ncr_strb_n_q, ncr_strb_n_d;
  logic [3:0] ncr_be_n_q, ncr_be_n_d;
  logic       scsi_dtack_q, scsi_dtack_d;
  logic       rd_latch_q, rd_latch_d;
  logic       timeout_q, timeout_d;
  logic [7:0] timeout_count_q, timeout_count_d;

  logic slack;
  logic start;

  assign slack = ~slack_sync_q[1];
  // Writes need at least one active byte lane; reads always use all four.
  assign start = scsi_cycle && z3_data && !FCS_n_sync && (READ || !(&DS_n_sync));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    slack_sync_d    = {slack_sync_q[0], SLACK_n};
    ncr_rw_d        = ncr_rw_q;
    ncr_be_n_d      = ncr_be_n_q;
    rd_latch_d      = 1'b0;
    timeout_d       = 1'b0;
    timeout_count_d = timeout_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETUP;
          cnt_d      = SetupLoad;
          ncr_rw_d   = READ;
          ncr_be_n_d = READ ? 4'b0000 : DS_n_sync;
        end
      end
      SETUP: begin
        if (FCS_n_sync) begin
          state_d = RECOVER;
          cnt_d   = RecoverLoad;
        end else if (cnt_q <= 8'd1) begin
          state_d = ACCESS;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACCESS: begin
        if (FCS_n_sync) begin
          state_d = RECOVER;
          cnt_d   = RecoverLoad;
        end else if (slack) begin
          // A real acknowledge beats the timeout limit in the same cycle.
          state_d    = ACK;
          cnt_d      = 8'd0;
          rd_latch_d = ncr_rw_q;
        end else if (cnt_q >= TimeoutLast) begin
          state_d   = ACK;
          cnt_d     = 8'd0;
          timeout_d = 1'b1;
          if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        if (FCS_n_sync) begin
          state_d = RECOVER;
          cnt_d   = RecoverLoad;
        end
      end
      RECOVER: begin
        if (cnt_q <= 8'd1) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Bus outputs are decoded from the next state so the registered copies
    // line up with the state register.
    ncr_cs_n_d   = !(state_d inside {SETUP, ACCESS, ACK});
    ncr_strb_n_d = !(state_d inside {ACCESS, ACK});
    scsi_dtack_d = (state_d == ACK);
    if (state_d inside {IDLE, RECOVER}) ncr_be_n_d = 4'b1111;
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order.
    if (RESET) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      slack_sync_q    <= 2'b11;
      ncr_cs_n_q      <= 1'b1;
      ncr_rw_q        <= 1'b1;
      ncr_strb_n_q    <= 1'b1;
      ncr_be_n_q      <= 4'b1111;
      scsi_dtack_q    <= 1'b0;
      rd_latch_q      <= 1'b0;
      timeout_q       <= 1'b0;
      timeout_count_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      slack_sync_q    <= slack_sync_d;
      ncr_cs_n_q      <= ncr_cs_n_d;
      ncr_rw_q        <= ncr_rw_d;
      ncr_strb_n_q    <= ncr_strb_n_d;
      ncr_be_n_q      <= ncr_be_n_d;
      scsi_dtack_q    <= scsi_dtack_d;
      rd_latch_q      <= rd_latch_d;
      timeout_q       <= timeout_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign ncr_cs_n      = ncr_cs_n_q;
  assign ncr_rw        = ncr_rw_q;
  assign ncr_strb_n    = ncr_strb_n_q;
  assign ncr_be_n      = ncr_be_n_q;
  assign scsi_dtack    = scsi_dtack_q;
  assign rd_latch      = rd_latch_q;
  assign timeout       = timeout_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_scsi_slave_bridge.sv
// -----------------------------------------------------------------------------
// tb_scsi_slave_bridge
//
// Directed testbench for scsi_slave_bridge with default parameters
// (SETUP 1, TIMEOUT 64, RECOVERY 2). Inputs are driven 1 ns after the rising
// edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_scsi_slave_bridge;

  logic       CLK;
  logic       RESET;
  logic       scsi_cycle;
  logic       z3_data;
  logic       FCS_n_sync;
  logic       READ;
  logic [3:0] DS_n_sync;
  logic       SLACK_n;
  logic       ncr_cs_n;
  logic       ncr_rw;
  logic       ncr_strb_n;
  logic [3:0] ncr_be_n;
  logic       scsi_dtack;
  logic       rd_latch;
  logic       timeout;
  logic [7:0] timeout_count;

  int n_checks = 0;
  int n_errors = 0;
  int rd_pulses = 0;
  int to_pulses = 0;
  int dtack_hi = 0;

  scsi_slave_bridge dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .scsi_cycle   (scsi_cycle),
    .z3_data      (z3_data),
    .FCS_n_sync   (FCS_n_sync),
    .READ         (READ),
    .DS_n_sync    (DS_n_sync),
    .SLACK_n      (SLACK_n),
    .ncr_cs_n     (ncr_cs_n),
    .ncr_rw       (ncr_rw),
    .ncr_strb_n   (ncr_strb_n),
    .ncr_be_n     (ncr_be_n),
    .scsi_dtack   (scsi_dtack),
    .rd_latch     (rd_latch),
    .timeout      (timeout),
    .timeout_count(timeout_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse/level counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (rd_latch)   rd_pulses++;
    if (timeout)    to_pulses++;
    if (scsi_dtack) dtack_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic request(input logic rd, input logic [3:0] ds);
    scsi_cycle = 1'b1;
    z3_data    = 1'b1;
    FCS_n_sync = 1'b0;
    READ       = rd;
    DS_n_sync  = ds;
  endtask

  task automatic end_cycle();
    scsi_cycle = 1'b0;
    z3_data    = 1'b0;
    FCS_n_sync = 1'b1;
    SLACK_n    = 1'b1;
    DS_n_sync  = 4'b1111;
  endtask

  task automatic wait_dtack(input string tag, input int max);
    for (int i = 0; i < max && !scsi_dtack; i++) tick();
    check(tag, 32'(scsi_dtack), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cs_n"},   32'(ncr_cs_n),      32'd1);
    check({pfx, "_strb_n"}, 32'(ncr_strb_n),    32'd1);
    check({pfx, "_be_n"},   32'(ncr_be_n),      32'hF);
    check({pfx, "_rw"},     32'(ncr_rw),        32'd1);
    check({pfx, "_dtack"},  32'(scsi_dtack),    32'd0);
    check({pfx, "_rdl"},    32'(rd_latch),      32'd0);
    check({pfx, "_to"},     32'(timeout),       32'd0);
    check({pfx, "_tcnt"},   32'(timeout_count), 32'd0);
  endtask

  initial begin
    int rd0, to0, d0, n, miss;

    RESET = 1'b1;
    end_cycle();
    READ = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");

    // ---- no start while FCS_n_sync is high after reset -------------------
    request(1'b1, 4'b1111);
    FCS_n_sync = 1'b1;
    RESET = 1'b0;
    tick(); tick(); tick();
    check("no_start_fcs_high", 32'(ncr_cs_n), 32'd1);

    // ---- read access, SLACK_n low 3 cycles after strobe -------------------
    rd0 = rd_pulses;
    FCS_n_sync = 1'b0;
    tick();                                              // SETUP
    check("rd_setup_cs_n", 32'(ncr_cs_n), 32'd0);
    check("rd_setup_strb_n", 32'(ncr_strb_n), 32'd1);
    check("rd_be_n", 32'(ncr_be_n), 32'h0);
    check("rd_rw", 32'(ncr_rw), 32'd1);
    tick();                                              // ACCESS
    check("rd_access_strb_n", 32'(ncr_strb_n), 32'd0);
    check("rd_access_cs_n", 32'(ncr_cs_n), 32'd0);
    tick(); tick(); tick();
    check("rd_no_early_dtack", 32'(scsi_dtack), 32'd0);
    SLACK_n = 1'b0;
    tick();                                              // first sample of SLACK_n low
    check("rd_dtack_sync1", 32'(scsi_dtack), 32'd0);
    tick();
    check("rd_dtack_sync2", 32'(scsi_dtack), 32'd0);
    tick();                                              // 2 cycles after first sample
    check("rd_dtack_rise", 32'(scsi_dtack), 32'd1);
    check("rd_latch_pulse", 32'(rd_latch), 32'd1);
    tick();
    check("rd_latch_one_cycle", 32'(rd_latch), 32'd0);
    check("rd_dtack_held", 32'(scsi_dtack), 32'd1);
    check("rd_ack_strb_n", 32'(ncr_strb_n), 32'd0);
    tick();
    check("rd_dtack_held2", 32'(scsi_dtack), 32'd1);
    end_cycle();
    tick();                                              // RECOVER
    check("rd_end_dtack", 32'(scsi_dtack), 32'd0);
    check("rd_end_cs_n", 32'(ncr_cs_n), 32'd1);
    check("rd_end_be_n", 32'(ncr_be_n), 32'hF);
    check("rd_pulse_count", 32'(rd_pulses - rd0), 32'd1);

    // ---- back-to-back write, DS_n_sync = 1100 ------------------------------
    request(1'b0, 4'b1100);
    rd0 = rd_pulses;
    tick();
    check("b2b_gap1_cs_n", 32'(ncr_cs_n), 32'd1);
    tick();
    check("b2b_gap2_cs_n", 32'(ncr_cs_n), 32'd1);
    tick();
    check("wr_setup_cs_n", 32'(ncr_cs_n), 32'd0);
    check("wr_be_n", 32'(ncr_be_n), 32'hC);
    check("wr_rw", 32'(ncr_rw), 32'd0);
    tick();
    SLACK_n = 1'b0;
    wait_dtack("wr_dtack", 10);
    check("wr_ack_be_n", 32'(ncr_be_n), 32'hC);
    check("wr_ack_rw", 32'(ncr_rw), 32'd0);
    tick();
    check("wr_no_rd_latch", 32'(rd_pulses - rd0), 32'd0);
    end_cycle();
    tick(); tick(); tick();

    // ---- abort during ACCESS ----------------------------------------------
    request(1'b1, 4'b1111);
    d0  = dtack_hi;
    to0 = to_pulses;
    rd0 = rd_pulses;
    tick(); tick(); tick(); tick();
    check("ab_in_access", 32'(ncr_strb_n), 32'd0);
    FCS_n_sync = 1'b1;
    tick();                                              // RECOVER
    check("ab_recover_cs_n", 32'(ncr_cs_n), 32'd1);
    check("ab_recover_strb_n", 32'(ncr_strb_n), 32'd1);
    check("ab_recover_be_n", 32'(ncr_be_n), 32'hF);
    FCS_n_sync = 1'b0;                                   // new request during RECOVER
    tick();
    check("ab_gap1_cs_n", 32'(ncr_cs_n), 32'd1);
    tick();
    check("ab_gap2_cs_n", 32'(ncr_cs_n), 32'd1);
    tick();
    check("ab_restart_cs_n", 32'(ncr_cs_n), 32'd0);
    check("ab_no_dtack", 32'(dtack_hi - d0), 32'd0);
    check("ab_no_rd_latch", 32'(rd_pulses - rd0), 32'd0);
    check("ab_no_timeout", 32'(to_pulses - to0), 32'd0);
    tick();
    SLACK_n = 1'b0;
    wait_dtack("ab_restart_dtack", 10);
    end_cycle();
    tick(); tick(); tick();

    // ---- timeout with SLACK_n held high ----------------------------------
    request(1'b0, 4'b0000);
    tick(); tick();
    check("to_access_entry", 32'(ncr_strb_n), 32'd0);
    n = 0;
    while (!timeout && n < 100) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd64);
    check("to_dtack", 32'(scsi_dtack), 32'd1);
    check("to_count1", 32'(timeout_count), 32'd1);
    tick();
    check("to_pulse_one_cycle", 32'(timeout), 32'd0);
    end_cycle();
    tick(); tick(); tick();

    // ---- slack arriving on the timeout-limit cycle wins -------------------
    request(1'b0, 4'b0000);
    to0 = to_pulses;
    tick(); tick();                                      // ACCESS entry
    repeat (61) tick();
    SLACK_n = 1'b0;                                      // visible when counter = 63
    tick(); tick();
    check("col_no_early_dtack", 32'(scsi_dtack), 32'd0);
    tick();
    check("col_dtack", 32'(scsi_dtack), 32'd1);
    check("col_no_timeout", 32'(to_pulses - to0), 32'd0);
    check("col_count_held", 32'(timeout_count), 32'd1);
    end_cycle();
    tick(); tick(); tick();

    // ---- 300 further timeouts saturate the counter ------------------------
    miss = 0;
    for (int k = 0; k < 300; k++) begin
      request(1'b0, 4'b0000);
      tick(); tick();
      n = 0;
      while (!timeout && n < 80) begin
        tick();
        n++;
      end
      if (!timeout) miss++;
      end_cycle();
      tick(); tick(); tick();
    end
    check("sat_all_timed_out", 32'(miss), 32'd0);
    check("sat_count", 32'(timeout_count), 32'd255);

    // ---- reset during ACK -------------------------------------------------
    request(1'b1, 4'b1111);
    tick(); tick();
    SLACK_n = 1'b0;
    wait_dtack("rst_ack_reached", 10);
    RESET = 1'b1;
    tick();
    check_reset_outputs("rst_in_ack");
    RESET = 1'b0;
    end_cycle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scsi_slave_bridge.md
SCSI_SLAVE_BRIDGE -- requirements
Module: scsi_slave_bridge

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1: CLK cycles from ncr_cs_n assertion to strobe assertion; legal range 1-15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: CLK cycles in ACCESS without SLACK before a forced acknowledge; legal range 2-255.
REQ-003 SHALL have parameter RECOVERY_CYCLES, default 2: idle CLK cycles enforced between NCR accesses; legal range 1-15.
REQ-004 SHALL have ports, in order:
- CLK  in  1  system clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- scsi_cycle  in  1  upstream Z3 FSM owns a cycle addressed to SCSI space.
- z3_data  in  1  upstream Z3 FSM is in its data phase.
- FCS_n_sync  in  1  synchronised Zorro III FCS_n; high means the cycle has ended.
- READ  in  1  Zorro III read (1) or write (0).
- DS_n_sync  in  4  synchronised Zorro III data strobes.
- SLACK_n  in  1  NCR 53C710 slave acknowledge; asynchronous.
- ncr_cs_n  out  1  NCR chip select.
- ncr_rw  out  1  NCR read/write; 1 = read.
- ncr_strb_n  out  1  NCR access strobe.
- ncr_be_n  out  4  NCR byte enables.
- scsi_dtack  out  1  acknowledge returned to the upstream Z3 FSM.
- rd_latch  out  1  one-cycle pulse that latches NCR read data into the Zorro data buffer.
- timeout  out  1  one-cycle pulse when an access is force-acknowledged.
- timeout_count  out  8  saturating count of timeouts.

Function
REQ-005 SHALL pass SLACK_n through a 2-FF synchroniser (reset value 11); slack = inverted output of the second stage.
REQ-006 SHALL use a single FSM with states IDLE, SETUP, ACCESS, ACK and RECOVER.
REQ-007 IDLE -> SETUP when scsi_cycle && z3_data && !FCS_n_sync && (READ || any DS_n_sync bit low).
- On that transition: capture READ into ncr_rw.
- ncr_be_n = 0000 for a read, otherwise DS_n_sync.
- Load the phase counter with SETUP_CYCLES.
REQ-008 SETUP: ncr_cs_n = 0; counter decrements each cycle; at 1 -> ACCESS with ncr_strb_n = 0 and the counter cleared.
REQ-009 ACCESS: ncr_cs_n = 0 and ncr_strb_n = 0; counter increments each cycle.
- slack -> ACK.
- Counter reaches TIMEOUT_CYCLES-1 without slack -> ACK; timeout = 1 for that one cycle.
REQ-010 If slack and the timeout limit occur in the same cycle, slack wins: no timeout pulse and no count increment.
REQ-011 On ACCESS -> ACK entry: rd_latch = 1 for exactly one cycle when ncr_rw = 1; never for writes.
REQ-012 ACK: scsi_dtack = 1 (level); NCR outputs stay asserted; the FSM holds until FCS_n_sync = 1, then goes to RECOVER.
REQ-013 SETUP or ACCESS with FCS_n_sync = 1 (aborted cycle) -> RECOVER in the next cycle.
- scsi_dtack, rd_latch and timeout are not asserted.
REQ-014 RECOVER: all NCR outputs deasserted (ncr_cs_n = 1, ncr_strb_n = 1, ncr_be_n = 1111).
- Stay exactly RECOVERY_CYCLES cycles, then IDLE.
- Requests seen during RECOVER are held off and accepted from IDLE.
REQ-015 scsi_dtack SHALL go low in the same cycle ACK is left; it is never high outside ACK.
REQ-016 timeout_count SHALL increment on each timeout pulse and saturate at 255 (no wrap).
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 ncr_rw and ncr_be_n SHALL stay stable from SETUP entry until RECOVER entry.

Reset
REQ-019 RESET high at a CLK edge SHALL, in any state including mid-access, force the following within one cycle:
- FSM to IDLE.
- ncr_cs_n = 1, ncr_strb_n = 1, ncr_be_n = 1111, ncr_rw = 1.
- scsi_dtack = 0, rd_latch = 0, timeout = 0, timeout_count = 0.
- Synchroniser = 11, counters = 0.
REQ-020 After RESET deasserts, the FSM SHALL NOT start a cycle while FCS_n_sync = 1.

Verification
REQ-021 Read, SLACK_n low 3 cycles after strobe -> ncr_cs_n low for 1 cycle before ncr_strb_n; scsi_dtack high 2 cycles after SLACK_n low (synchroniser) and held until FCS_n_sync high; one rd_latch pulse; ncr_be_n = 0000.
REQ-022 Write, DS_n_sync = 1100, SLACK responds -> ncr_be_n = 1100, ncr_rw = 0, no rd_latch, scsi_dtack asserted.
REQ-023 SLACK_n held high -> timeout pulse exactly 64 cycles after ACCESS entry, scsi_dtack asserted, timeout_count = 1; 300 timeouts -> timeout_count = 255.
REQ-024 FCS_n_sync rises during ACCESS -> RECOVER next cycle, scsi_dtack never high, 2 idle cycles, then IDLE.
REQ-025 Back-to-back requests -> at least 2 cycles with ncr_cs_n high between accesses; RESET asserted during ACK -> all outputs at reset values on the next cycle.
